alu_multiword_sequencer: RTL



---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_multiword_sequencer_if.sv | 29 ++
 rtl/ArithmeticLogicUnit.sv | 74 +++++++
 rtl/alu_multiword_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and types for the multi-word ALU sequencer
//
// Provides the 16-bit ALU FunSel codes the sequencer uses, the FlagsOut bit
// positions {Z,C,N,O}, the wide-operation encoding, the sequencer state enum
// and the per-cycle ALU drive bundle.
package alu_pkg;

  localparam logic [4:0] FS16_A   = 5'b10000;
  localparam logic [4:0] FS16_ADD = 5'b10100;
  localparam logic [4:0] FS16_ADC = 5'b10101;
  localparam logic [4:0] FS16_LSL = 5'b11011;
  localparam logic [4:0] FS16_LSR = 5'b11100;
  localparam logic [4:0] FS16_CSL = 5'b11110;
  localparam logic [4:0] FS16_CSR = 5'b11111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_LSL = 2'b10,
    OP_LSR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESET,
    ST_STEP,
    ST_FLAGS,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  fs;
  } alu_drive_t;

endpackage

// File: rtl/alu_multiword_sequencer_if.sv
// rtl/alu_multiword_sequencer_if.sv - bus between the wide-op sequencer and the 16-bit ALU
//
// Signals:
//   AluA, AluB   16  operands to the ALU
//   AluFunSel     5  ALU function select
//   AluWF         1  ALU flag write enable
//   AluOut       16  combinational ALU result
//   AluFlags      4  registered ALU flags {Z,C,N,O}
// master: the sequencer (drives operands/function); slave: the ALU.
interface alu_multiword_sequencer_if;

  logic [15:0] AluA;
  logic [15:0] AluB;
  logic [4:0]  AluFunSel;
  logic        AluWF;
  logic [15:0] AluOut;
  logic [3:0]  AluFlags;

  modport master (
    output AluA, AluB, AluFunSel, AluWF,
    input  AluOut, AluFlags
  );

  modport slave (
    input  AluA, AluB, AluFunSel, AluWF,
    output AluOut, AluFlags
  );

endinterface

// File: rtl/ArithmeticLogicUnit.sv
// rtl/ArithmeticLogicUnit.sv - 16-bit ALU subset used by the wide-op sequencer
//
// Ports:
//   Clock     in   rising-edge clock for the flag register
//   Reset     in   synchronous active-low reset of FlagsOut
//   A, B      in   16-bit operands
//   FunSel    in   function select (16-bit codes from alu_pkg)
//   WF        in   flag write enable; flags update on Clock when WF=1
//   ALUOut    out  combinational result
//   FlagsOut  out  registered {Z,C,N,O}
// Functions: A, A+B, A+B+C, LSL, LSR, CSL/CSR (rotate through C).
// Shifts leave O unchanged; unlisted codes pass A and keep C/O.
module ArithmeticLogicUnit
  import alu_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [4:0]  FunSel,
  input  logic        WF,
  output logic [15:0] ALUOut,
  output logic [3:0]  FlagsOut
);

  logic [16:0] sum;
  logic [15:0] out;
  logic        c_new;
  logic        o_new;

  always_comb begin
    sum   = '0;
    out   = A;
    c_new = FlagsOut[FLAG_C];
    o_new = FlagsOut[FLAG_O];
    case (FunSel)
      FS16_ADD, FS16_ADC: begin
        sum   = {1'b0, A} + {1'b0, B}
              + {16'h0000, (FunSel == FS16_ADC) & FlagsOut[FLAG_C]};
        out   = sum[15:0];
        c_new = sum[16];
        o_new = (A[15] == B[15]) && (sum[15] != A[15]);
      end
      FS16_LSL: begin
        out   = {A[14:0], 1'b0};
        c_new = A[15];
      end
      FS16_LSR: begin
        out   = {1'b0, A[15:1]};
        c_new = A[0];
      end
      FS16_CSL: begin
        out   = {A[14:0], FlagsOut[FLAG_C]};
        c_new = A[15];
      end
      FS16_CSR: begin
        out   = {FlagsOut[FLAG_C], A[15:1]};
        c_new = A[0];
      end
      default: ;
    endcase
  end

  assign ALUOut = out;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      FlagsOut <= '0;
    end else if (WF) begin
      FlagsOut <= {(out == 16'h0000), c_new, out[15], o_new};
    end
  end

endmodule

// File: rtl/alu_multiword_sequencer.sv
// rtl/alu_multiword_sequencer.sv - runs 16*WORDS-bit ADD/SUB/LSL/LSR through a 16-bit ALU
//
// Ports:
//   Clock, Reset        clock; synchronous active-low reset
//   Start, Op           launch request (sampled only in IDLE) and operation
//   OpA, OpB            wide operands, captured on an accepted Start
//   Busy, Done          busy through the DONE cycle; one-cycle completion pulse
//   Result, ResultFlags wide result and {Z,C,N,O}, held until the next Start
//   alu                 master side of the ALU bus (registered drive outputs)
// One word is processed per STEP cycle; carry is chained word to word
// through the ALU's own C flag.
module alu_multiword_sequencer
  import alu_pkg::*;
#(
  parameter int WORDS = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic [1:0]             Op,
  input  logic [16*WORDS-1:0]    OpA,
  input  logic [16*WORDS-1:0]    OpB,
  output logic                   Busy,
  output logic                   Done,
  output logic [16*WORDS-1:0]    Result,
  output logic [3:0]             ResultFlags,
  alu_multiword_sequencer_if.master alu
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_e              state;
  op_e                 op_q;
  logic [16*WORDS-1:0] a_q;
  logic [16*WORDS-1:0] b_q;
  logic [IW-1:0]       idx;
  logic                zacc;

  op_e                 op_in;
  logic [IW-1:0]       start_idx;
  logic [IW-1:0]       step_idx;
  logic                last_word;
  alu_drive_t          start_drv;
  alu_drive_t          step_drv;
  logic                flags_unused;

  // Z and N come from the wide result, not from the ALU's last word.
  assign flags_unused = ^{alu.AluFlags[FLAG_Z], alu.AluFlags[FLAG_N]};
  assign op_in        = op_e'(Op);

  // ALU drive for word i. The first word processed (word 0, or the top word
  // for LSR) uses the non-carry form so no stale C leaks in; SUB is A+~B+C
  // everywhere because PRESET has already forced C=1.
  function automatic alu_drive_t step_drive(input op_e op,
                                            input logic [16*WORDS-1:0] va,
                                            input logic [16*WORDS-1:0] vb,
                                            input logic [IW-1:0] i);
    alu_drive_t d;
    logic       first;
    first = (op == OP_LSR) ? (i == LAST_IDX) : (i == '0);
    d.a   = va[16*int'(i) +: 16];
    d.b   = 16'h0000;
    case (op)
      OP_ADD: begin
        d.b  = vb[16*int'(i) +: 16];
        d.fs = first ? FS16_ADD : FS16_ADC;
      end
      OP_SUB: begin
        d.b  = ~vb[16*int'(i) +: 16];
        d.fs = FS16_ADC;
      end
      OP_LSL:  d.fs = first ? FS16_LSL : FS16_CSL;
      default: d.fs = first ? FS16_LSR : FS16_CSR;
    endcase
    return d;
  endfunction

  // Alu* are registered, so the drive for the next cycle's word is chosen
  // here and loaded at the edge that enters that cycle.
  always_comb begin
    start_idx = (op_in == OP_LSR) ? LAST_IDX : '0;
    last_word = (op_q == OP_LSR) ? (idx == '0) : (idx == LAST_IDX);
    step_idx  = idx;
    if (state == ST_STEP) begin
      step_idx = (op_q == OP_LSR) ? idx - 1'b1 : idx + 1'b1;
    end
    start_drv = step_drive(op_in, OpA, OpB, start_idx);
    step_drv  = step_drive(op_q, a_q, b_q, step_idx);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state         <= ST_IDLE;
      op_q          <= OP_ADD;
      a_q           <= '0;
      b_q           <= '0;
      idx           <= '0;
      zacc          <= 1'b1;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Result        <= '0;
      ResultFlags   <= '0;
      alu.AluA      <= '0;
      alu.AluB      <= '0;
      alu.AluFunSel <= FS16_A;
      alu.AluWF     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            a_q       <= OpA;
            b_q       <= OpB;
            op_q      <= op_in;
            zacc      <= 1'b1;
            idx       <= start_idx;
            Busy      <= 1'b1;
            alu.AluWF <= 1'b1;
            if (op_in == OP_SUB) begin
              // FFFF+0001 leaves C=1: the +1 of the two's complement.
              state         <= ST_PRESET;
              alu.AluA      <= 16'hFFFF;
              alu.AluB      <= 16'h0001;
              alu.AluFunSel <= FS16_ADD;
            end else begin
              state         <= ST_STEP;
              alu.AluA      <= start_drv.a;
              alu.AluB      <= start_drv.b;
              alu.AluFunSel <= start_drv.fs;
            end
          end
        end
        ST_PRESET: begin
          state         <= ST_STEP;
          alu.AluA      <= step_drv.a;
          alu.AluB      <= step_drv.b;
          alu.AluFunSel <= step_drv.fs;
        end
        ST_STEP: begin
          Result[16*int'(idx) +: 16] <= alu.AluOut;
          zacc <= zacc & (alu.AluOut == 16'h0000);
          if (last_word) begin
            state         <= ST_FLAGS;
            alu.AluWF     <= 1'b0;
            alu.AluA      <= '0;
            alu.AluB      <= '0;
            alu.AluFunSel <= FS16_A;
          end else begin
            idx           <= step_idx;
            alu.AluA      <= step_drv.a;
            alu.AluB      <= step_drv.b;
            alu.AluFunSel <= step_drv.fs;
          end
        end
        ST_FLAGS: begin
          ResultFlags <= {zacc, alu.AluFlags[FLAG_C], Result[16*WORDS-1],
                          ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu.AluFlags[FLAG_O] : 1'b0};
          Done  <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
